// File: rtl/vga_timing_ctrl_pkg.sv
// vga_timing_pkg
// Shared definitions for the 640x480@60 raster timing generator:
// the per-axis phase encoding, the standard VGA timing constants,
// the derived line/frame totals and the counter width.
// No ports (package).
package vga_timing_pkg;

    localparam int unsigned CNT_W = 10;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    localparam int unsigned H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Sync pulses are active-low for 640x480.
    localparam logic VGA_SYNC_POL = 1'b0;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } phase_t;

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// vga_timing_ctrl_if
// Bundles the pixel-rate enable and the timing outputs between the
// raster timing generator and the pixel generator.
//   Enable      pixel-rate tick into the generator
//   HSYNC/VSYNC sync levels
//   VideoOn     both axes in the visible region
//   X/Y         raster position
//   LineStart   one-cycle pulse when X becomes 0
//   FrameStart  one-cycle pulse when X and Y both become 0
// master = timing generator, slave = consumer.
interface vga_timing_ctrl_if;
    import vga_timing_pkg::*;

    logic             Enable;
    logic             HSYNC;
    logic             VSYNC;
    logic             VideoOn;
    logic [CNT_W-1:0] X;
    logic [CNT_W-1:0] Y;
    logic             LineStart;
    logic             FrameStart;

    modport master (
        input  Enable,
        output HSYNC, VSYNC, VideoOn, X, Y, LineStart, FrameStart
    );

    modport slave (
        output Enable,
        input  HSYNC, VSYNC, VideoOn, X, Y, LineStart, FrameStart
    );

endinterface

// File: rtl/vga_phase_axis.sv
// vga_phase_axis
// One raster axis: a phase FSM with a per-phase down-counter and a
// separate up-counting position.
//   clk, reset  clock, synchronous active-high reset
//   advance     step the axis by one position this cycle
//   count       registered position, 0 .. total-1
//   phase_next  phase that count will be in after this edge
//   wrap        high in the cycle where count goes from total-1 to 0
//
// state  | meaning
// ACTIVE | visible region
// FRONT  | front porch
// SYNC   | sync pulse
// BACK   | back porch; leaving it wraps the axis
module vga_phase_axis
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE_LEN = VGA_H_ACTIVE,
    parameter int unsigned FP_LEN     = VGA_H_FP,
    parameter int unsigned SYNC_LEN   = VGA_H_SYNC,
    parameter int unsigned BP_LEN     = VGA_H_BP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    output logic [CNT_W-1:0] count,
    output phase_t           phase_next,
    output logic             wrap
);

    phase_t           phase;
    logic [CNT_W-1:0] remain;
    logic [CNT_W-1:0] remain_next;
    logic [CNT_W-1:0] count_next;

    // Phase counters hold (length - 1) so terminal count is zero.
    function automatic logic [CNT_W-1:0] load_val(input phase_t p);
        case (p)
            ACTIVE:  return CNT_W'(ACTIVE_LEN - 1);
            FRONT:   return CNT_W'(FP_LEN - 1);
            SYNC:    return CNT_W'(SYNC_LEN - 1);
            default: return CNT_W'(BP_LEN - 1);
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            phase  <= ACTIVE;
            remain <= load_val(ACTIVE);
            count  <= '0;
        end else begin
            phase  <= phase_next;
            remain <= remain_next;
            count  <= count_next;
        end
    end

    always_comb begin
        phase_next  = phase;
        remain_next = remain;
        count_next  = count;
        wrap        = 1'b0;
        if (advance) begin
            count_next = count + CNT_W'(1);
            if (remain == '0) begin
                case (phase)
                    ACTIVE:  phase_next = FRONT;
                    FRONT:   phase_next = SYNC;
                    SYNC:    phase_next = BACK;
                    default: begin
                        phase_next = ACTIVE;
                        count_next = '0;
                        wrap       = 1'b1;
                    end
                endcase
                remain_next = load_val(phase_next);
            end else begin
                remain_next = remain - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl
// 640x480@60 raster timing generator. A horizontal axis steps on every
// pixel-rate Enable; the vertical axis steps only when the horizontal
// axis wraps. Sync and blank come purely from the axis phases.
//   CLK    system clock
//   Reset  synchronous active-high reset
//   vga    master side of vga_timing_ctrl_if (Enable in, timing out)
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter logic        SYNC_POL = VGA_SYNC_POL
) (
    input  logic               CLK,
    input  logic               Reset,
    vga_timing_ctrl_if.master  vga
);

    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    phase_t           h_phase_next;
    phase_t           v_phase_next;
    logic             h_wrap;
    logic             v_wrap;
    logic             v_advance;

    logic hsync_q;
    logic vsync_q;
    logic video_on_q;
    logic line_start_q;
    logic frame_start_q;

    assign v_advance = vga.Enable & h_wrap;

    vga_phase_axis #(
        .ACTIVE_LEN (H_ACTIVE),
        .FP_LEN     (H_FP),
        .SYNC_LEN   (H_SYNC),
        .BP_LEN     (H_BP)
    ) u_h_axis (
        .clk        (CLK),
        .reset      (Reset),
        .advance    (vga.Enable),
        .count      (h_count),
        .phase_next (h_phase_next),
        .wrap       (h_wrap)
    );

    vga_phase_axis #(
        .ACTIVE_LEN (V_ACTIVE),
        .FP_LEN     (V_FP),
        .SYNC_LEN   (V_SYNC),
        .BP_LEN     (V_BP)
    ) u_v_axis (
        .clk        (CLK),
        .reset      (Reset),
        .advance    (v_advance),
        .count      (v_count),
        .phase_next (v_phase_next),
        .wrap       (v_wrap)
    );

    // Decode from next-phase so the registered outputs line up with the
    // X/Y registered on the same edge. VideoOn stays 0 after reset until
    // the first enabled edge.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            // h_wrap is already qualified by Enable, v_wrap by h_wrap.
            line_start_q  <= h_wrap;
            frame_start_q <= v_wrap;
            if (vga.Enable) begin
                hsync_q    <= (h_phase_next == SYNC) ? SYNC_POL : ~SYNC_POL;
                vsync_q    <= (v_phase_next == SYNC) ? SYNC_POL : ~SYNC_POL;
                video_on_q <= (h_phase_next == ACTIVE) && (v_phase_next == ACTIVE);
            end
        end
    end

    assign vga.X          = h_count;
    assign vga.Y          = v_count;
    assign vga.HSYNC      = hsync_q;
    assign vga.VSYNC      = vsync_q;
    assign vga.VideoOn    = video_on_q;
    assign vga.LineStart  = line_start_q;
    assign vga.FrameStart = frame_start_q;

endmodule
